// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one combinational ALU between the control FSM (req0)
// and the PC/branch unit (req1); registers operands, waits the op latency, returns a result.
module alu_arbiter #(
  parameter int DATA_WIDTH = 32,
  parameter int MUL_LAT    = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req0_valid,
  output logic                  req0_ready,
  input  logic [3:0]            req0_op,
  input  logic [DATA_WIDTH-1:0] req0_a,
  input  logic [DATA_WIDTH-1:0] req0_b,
  input  logic                  req1_valid,
  output logic                  req1_ready,
  input  logic [3:0]            req1_op,
  input  logic [DATA_WIDTH-1:0] req1_a,
  input  logic [DATA_WIDTH-1:0] req1_b,
  output logic [DATA_WIDTH-1:0] alu_a,
  output logic [DATA_WIDTH-1:0] alu_b,
  output logic [3:0]            alu_ctrl,
  input  logic [DATA_WIDTH-1:0] alu_result,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic                  rsp_id,
  output logic [DATA_WIDTH-1:0] rsp_result,
  output logic                  rsp_zero,
  output logic                  rsp_err,
  output logic                  busy
);

  // Handshake: a transfer happens on a rising edge where valid && ready are both high;
  // a requester holds valid and payload stable until it sees ready.

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_MUL  = 4'd3;
  localparam logic [3:0] OP_LAST = 4'd9;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t                state;
  logic                  last_grant;
  logic [3:0]            cnt;
  logic                  grant;
  logic                  accept;
  logic [3:0]            need;
  logic [3:0]            sel_op;
  logic [DATA_WIDTH-1:0] sel_a;
  logic [DATA_WIDTH-1:0] sel_b;

  // A lone requester always wins; on a tie the one that did not own the last response wins.
  always_comb begin
    grant = 1'b0;
    if (req0_valid && req1_valid) grant = ~last_grant;
    else if (req1_valid)          grant = 1'b1;
  end

  assign req0_ready = (state == IDLE) && !grant && req0_valid;
  assign req1_ready = (state == IDLE) &&  grant && req1_valid;
  assign accept     = req0_ready || req1_ready;
  assign busy       = (state != IDLE);

  assign sel_op = grant ? req1_op : req0_op;
  assign sel_a  = grant ? req1_a  : req0_a;
  assign sel_b  = grant ? req1_b  : req0_b;
  assign need   = (alu_ctrl == OP_MUL) ? 4'(MUL_LAT) : 4'd1;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      last_grant <= 1'b1;
      cnt        <= 4'd0;
      alu_a      <= '0;
      alu_b      <= '0;
      alu_ctrl   <= OP_ADD;
      rsp_valid  <= 1'b0;
      rsp_id     <= 1'b0;
      rsp_result <= '0;
      rsp_zero   <= 1'b0;
      rsp_err    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            alu_ctrl <= sel_op;
            alu_a    <= sel_a;
            alu_b    <= sel_b;
            rsp_id   <= grant;
            if (sel_op > OP_LAST) begin
              rsp_err    <= 1'b1;
              rsp_result <= '0;
              rsp_zero   <= 1'b0;
              rsp_valid  <= 1'b1;
              state      <= RESP;
            end else begin
              cnt   <= 4'd1;
              state <= EXEC;
            end
          end
        end
        EXEC: begin
          if (cnt == need) begin
            rsp_result <= alu_result;
            rsp_zero   <= (alu_result == '0);
            rsp_err    <= 1'b0;
            rsp_valid  <= 1'b1;
            state      <= RESP;
          end else begin
            cnt <= cnt + 4'd1;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            last_grant <= rsp_id;
            rsp_valid  <= 1'b0;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: ALU stub, per-requester op queues, and a transaction-level
// timing/arbitration model checked every cycle.
module tb_alu_arbiter;
  localparam int W       = 32;
  localparam int MUL_LAT = 3;

  typedef struct {
    logic [3:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
  } req_t;

  logic         clk;
  logic         rst;
  logic         req0_valid, req0_ready, req1_valid, req1_ready;
  logic [3:0]   req0_op, req1_op, alu_ctrl;
  logic [W-1:0] req0_a, req0_b, req1_a, req1_b;
  logic [W-1:0] alu_a, alu_b, alu_result, rsp_result;
  logic         rsp_valid, rsp_ready, rsp_id, rsp_zero, rsp_err, busy;

  alu_arbiter #(.DATA_WIDTH(W), .MUL_LAT(MUL_LAT)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
    .req0_a(req0_a), .req0_b(req0_b),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
    .req1_a(req1_a), .req1_b(req1_b),
    .alu_a(alu_a), .alu_b(alu_b), .alu_ctrl(alu_ctrl), .alu_result(alu_result),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_result(rsp_result), .rsp_zero(rsp_zero), .rsp_err(rsp_err), .busy(busy)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- ALU stub ----------------
  function automatic logic [W-1:0] alu_fn(input logic [3:0] op, input logic [W-1:0] a,
                                          input logic [W-1:0] b);
    logic [4:0] sh;
    sh = b[4:0];
    case (op)
      4'd0:    return a + b;
      4'd1:    return a - b;
      4'd2:    return '0 - b;
      4'd3:    return a * b;
      4'd4:    return a & b;
      4'd5:    return a | b;
      4'd6:    return a & ~b;
      4'd7:    return a ^ b;
      4'd8:    return a << sh;
      4'd9:    return a >> sh;
      default: return 32'hDEAD_BEEF;
    endcase
  endfunction

  always_comb alu_result = alu_fn(alu_ctrl, alu_a, alu_b);

  // ---------------- scoreboard / model state ----------------
  int           checks = 0;
  int           errors = 0;
  int           cyc = 0;
  req_t         q0[$];
  req_t         q1[$];
  logic [W-1:0] exp_q[$];
  int           grant_log[$];
  bit           active = 0;
  bit           last = 1;
  bit           checks_on = 0;
  bit           just_reset = 0;
  bit           rst_next = 1;
  int           rdy_mode = 0;
  bit           cur_id;
  logic [3:0]   cur_op;
  logic [W-1:0] cur_a, cur_b;
  int           rsp_cyc = 0;
  logic [W-1:0] last_result;
  bit           last_zero, last_err;

  task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h cycle=%0d", tag, got, exp, cyc);
    end
  endtask

  function automatic int op_lat(input logic [3:0] op);
    if (op == 4'd3) return MUL_LAT;
    if (op <= 4'd9) return 1;
    return 0;
  endfunction

  // ---------------- driver / per-cycle checker ----------------
  task automatic step();
    bit   v0, v1, g, er0, er1, ev;
    req_t r;
    @(posedge clk);
    #1;
    rst        = rst_next;
    req0_valid = (q0.size() > 0);
    req1_valid = (q1.size() > 0);
    if (req0_valid) begin req0_op = q0[0].op; req0_a = q0[0].a; req0_b = q0[0].b; end
    else begin req0_op = '0; req0_a = '0; req0_b = '0; end
    if (req1_valid) begin req1_op = q1[0].op; req1_a = q1[0].a; req1_b = q1[0].b; end
    else begin req1_op = '0; req1_a = '0; req1_b = '0; end
    case (rdy_mode)
      1:       rsp_ready = 1'($urandom_range(0, 1));
      2:       rsp_ready = active && (cyc >= rsp_cyc + 5);
      default: rsp_ready = 1'b1;
    endcase
    @(negedge clk);
    v0  = req0_valid;
    v1  = req1_valid;
    g   = (v0 && v1) ? !last : v1;
    er0 = !active && v0 && !g;
    er1 = !active && v1 && g;
    ev  = active && (cyc >= rsp_cyc);
    if (checks_on) begin
      check("req0_ready", 32'(req0_ready), 32'(er0));
      check("req1_ready", 32'(req1_ready), 32'(er1));
      check("one_ready", 32'(req0_ready & req1_ready), 32'd0);
      check("busy", 32'(busy), 32'(active));
      check("rsp_valid", 32'(rsp_valid), 32'(ev));
      if (ev) begin
        check("rsp_id", 32'(rsp_id), 32'(cur_id));
        check("rsp_result", rsp_result, exp_q[0]);
        check("rsp_zero", 32'(rsp_zero), 32'((cur_op <= 4'd9) && (exp_q[0] == '0)));
        check("rsp_err", 32'(rsp_err), 32'(cur_op > 4'd9));
      end
      if (active && (cyc < rsp_cyc)) begin
        check("exec_alu_ctrl", 32'(alu_ctrl), 32'(cur_op));
        check("exec_alu_a", alu_a, cur_a);
        check("exec_alu_b", alu_b, cur_b);
      end
      if (just_reset && !rst) begin
        check("rst_alu_a", alu_a, '0);
        check("rst_alu_b", alu_b, '0);
        check("rst_alu_ctrl", 32'(alu_ctrl), 32'd0);
        check("rst_rsp_id", 32'(rsp_id), 32'd0);
        check("rst_rsp_result", rsp_result, '0);
        check("rst_rsp_zero", 32'(rsp_zero), 32'd0);
        check("rst_rsp_err", 32'(rsp_err), 32'd0);
        just_reset = 0;
      end
    end
    if (rst) begin
      active     = 0;
      last       = 1;
      just_reset = 1;
      exp_q.delete();
    end else if (checks_on) begin
      if (ev && rsp_ready) begin
        last_result = rsp_result;
        last_zero   = rsp_zero;
        last_err    = rsp_err;
        last        = cur_id;
        active      = 0;
        void'(exp_q.pop_front());
      end else if (er0 || er1) begin
        if (er0) r = q0.pop_front();
        else     r = q1.pop_front();
        cur_id  = er1;
        cur_op  = r.op;
        cur_a   = r.a;
        cur_b   = r.b;
        rsp_cyc = cyc + 1 + op_lat(r.op);
        active  = 1;
        exp_q.push_back((r.op > 4'd9) ? '0 : alu_fn(r.op, r.a, r.b));
        grant_log.push_back(int'(er1));
      end
    end
    cyc++;
  endtask

  task automatic push(input int id, input logic [3:0] op, input logic [W-1:0] a,
                      input logic [W-1:0] b);
    req_t r;
    r.op = op; r.a = a; r.b = b;
    if (id == 0) q0.push_back(r);
    else         q1.push_back(r);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((q0.size() > 0 || q1.size() > 0 || active) && n < 500) begin
      step();
      n++;
    end
    if (n >= 500) check("drain_timeout", 32'd1, 32'd0);
  endtask

  function automatic logic [W-1:0] rand_operand();
    if ($urandom_range(0, 3) == 0) return W'($urandom_range(0, 3));
    return W'($urandom());
  endfunction

  task automatic push_random(input int id);
    logic [3:0]   op;
    logic [W-1:0] a, b;
    op = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(10, 15)) : 4'($urandom_range(0, 9));
    a  = rand_operand();
    b  = ($urandom_range(0, 5) == 0) ? a : rand_operand();
    push(id, op, a, b);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    rst = 1'b1; rsp_ready = 1'b1;
    req0_valid = 1'b0; req0_op = '0; req0_a = '0; req0_b = '0;
    req1_valid = 1'b0; req1_op = '0; req1_a = '0; req1_b = '0;
    repeat (3) step();
    rst_next  = 0;
    checks_on = 1;
    step();

    push(0, 4'd0, 32'd5, 32'd7);
    drain();
    check("add_5_7", last_result, 32'd12);

    push(1, 4'd1, 32'd9, 32'd9);
    drain();
    check("sub_9_9_zero", 32'(last_zero), 32'd1);

    grant_log.delete();
    for (int i = 0; i < 2; i++) begin
      push(0, 4'd0, W'($urandom()), W'($urandom()));
      push(1, 4'd0, W'($urandom()), W'($urandom()));
    end
    drain();
    check("tie_count", 32'(grant_log.size()), 32'd4);
    for (int i = 0; i < grant_log.size() && i < 4; i++)
      check("tie_order", 32'(grant_log[i]), 32'(i % 2));

    push(0, 4'd3, 32'd6, 32'd7);
    drain();
    check("mul_6_7", last_result, 32'd42);

    push(1, 4'hC, 32'd1, 32'd2);
    drain();
    check("illegal_err", 32'(last_err), 32'd1);

    rdy_mode = 2;
    push(0, 4'd0, 32'd100, 32'd23);
    push(1, 4'd7, 32'hF0F0, 32'h0FF0);
    drain();
    rdy_mode = 0;

    push(0, 4'd3, 32'd3, 32'd4);
    while (!active) step();
    rst_next = 1;
    step();
    rst_next = 0;
    step();
    step();
    grant_log.delete();
    push(0, 4'd0, 32'd1, 32'd1);
    push(1, 4'd0, 32'd2, 32'd2);
    drain();
    check("post_rst_first_grant", 32'((grant_log.size() > 0) ? grant_log[0] : 9), 32'd0);

    rdy_mode = 1;
    for (int i = 0; i < 400; i++) begin
      if (q0.size() < 3 && $urandom_range(0, 3) == 0) push_random(0);
      if (q1.size() < 3 && $urandom_range(0, 3) == 0) push_random(1);
      step();
    end
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
